// File: rtl/pulse_period_meter.sv
// Purpose: measures the clk-cycle interval between rising edges of a (possibly asynchronous) pulse train.
// Latency: an input rising edge first sampled at clock E0 updates period/period_valid/locked at E2.
// Backpressure: none; period_valid and timeout are single-cycle strobes with no handshake.
module pulse_period_meter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ena,
    input  logic         pulse_in,
    output logic [N-1:0] period,
    output logic         period_valid,
    output logic         timeout,
    output logic         locked
);

    localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // Synchronizer (s0, s1) plus the delayed copy (s2) used for edge detection.
    logic s0_q;
    logic s1_q;
    logic s2_q;

    state_t       state_q;
    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_inc_d;
    logic [N-1:0] period_q;
    logic         period_vld_q;
    logic         timeout_q;
    logic         locked_q;
    logic         edge_d;

    // Sync flops reset high so a line already high at reset release is not seen as a rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s0_q <= pulse_in;
            s1_q <= s0_q;
            s2_q <= s1_q;
        end
    end

    // Rising edge of the synchronized pulse, and the saturating-free increment of the interval counter.
    always_comb begin
        edge_d    = s1_q & ~s2_q;
        cnt_inc_d = cnt_q + N'(1);
    end

    // Two-state measurement FSM; all outputs are registered here. Edge beats the MAX check.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            timeout_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else if (!ena) begin
            // Disarm: period is deliberately held so software can still read the last result.
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            period_vld_q <= 1'b0;
            timeout_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            period_vld_q <= 1'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (edge_d) begin
                        // First edge only arms; there is no reference edge to measure from yet.
                        state_q  <= ST_MEASURE;
                        cnt_q    <= N'(1);
                        locked_q <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (edge_d) begin
                        period_q     <= cnt_q;
                        period_vld_q <= 1'b1;
                        cnt_q        <= N'(1);
                    end else if (cnt_q == CNT_MAX) begin
                        // Interval no longer representable: drop lock rather than wrap.
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign period       = period_q;
    assign period_valid = period_vld_q;
    assign timeout      = timeout_q;
    assign locked       = locked_q;

    // The two strobes report mutually exclusive events.
    a_strobe_excl : assert property (@(posedge clk) disable iff (reset) !(period_vld_q && timeout_q));

    // locked mirrors the registered state.
    a_locked_state : assert property (@(posedge clk) disable iff (reset) locked_q == (state_q == ST_MEASURE));

endmodule

// File: tb/tb_pulse_period_meter.sv
module tb_pulse_period_meter;

    typedef struct packed {
        logic       is_to;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       ena8;
    logic       ena4;
    logic       pulse8;
    logic       pulse4;
    logic [7:0] period8;
    logic [3:0] period4;
    logic       pv8;
    logic       pv4;
    logic       to8;
    logic       to4;
    logic       locked8;
    logic       locked4;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8;
    exp_t e4;

    pulse_period_meter #(.N(8)) u_dut8 (
        .clk          (clk),
        .reset        (reset),
        .ena          (ena8),
        .pulse_in     (pulse8),
        .period       (period8),
        .period_valid (pv8),
        .timeout      (to8),
        .locked       (locked8)
    );

    pulse_period_meter #(.N(4)) u_dut4 (
        .clk          (clk),
        .reset        (reset),
        .ena          (ena4),
        .pulse_in     (pulse4),
        .period       (period4),
        .period_valid (pv4),
        .timeout      (to4),
        .locked       (locked4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int sel, input logic is_to, input logic [7:0] val);
        exp_t e;
        e.is_to = is_to;
        e.val   = val;
        if (sel == 8) q8.push_back(e);
        else          q4.push_back(e);
    endtask

    // One pulse: high for hi cycles then low for lo cycles; rising edges are hi+lo apart.
    task automatic pulse_gap(input int sel, input int hi, input int lo);
        if (sel == 8) pulse8 = 1'b1; else pulse4 = 1'b1;
        tick(hi);
        if (sel == 8) pulse8 = 1'b0; else pulse4 = 1'b0;
        tick(lo);
    endtask

    // Scoreboard side: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && (pv8 || to8)) begin
            check_eq("excl8", 32'(pv8 & to8), 32'd0);
            if (q8.size() == 0) begin
                check_eq("unexp_strobe8", 32'({pv8, to8}), 32'd0);
            end else begin
                e8 = q8.pop_front();
                check_eq("kind8", 32'(to8), 32'(e8.is_to));
                check_eq("period8", 32'(period8), 32'(e8.val));
            end
        end
        if (!reset && (pv4 || to4)) begin
            check_eq("excl4", 32'(pv4 & to4), 32'd0);
            if (q4.size() == 0) begin
                check_eq("unexp_strobe4", 32'({pv4, to4}), 32'd0);
            end else begin
                e4 = q4.pop_front();
                check_eq("kind4", 32'(to4), 32'(e4.is_to));
                check_eq("period4", 32'(period4), 32'(e4.val));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        ena8   = 1'b0;
        ena4   = 1'b0;
        pulse8 = 1'b0;
        pulse4 = 1'b0;
        tick(3);
        check_eq("rst_period", 32'(period8), 32'd0);
        check_eq("rst_valid", 32'(pv8), 32'd0);
        check_eq("rst_timeout", 32'(to8), 32'd0);
        check_eq("rst_locked", 32'(locked8), 32'd0);
        reset = 1'b0;
        ena8  = 1'b1;
        tick(2);

        // Period-5 train, 1-cycle pulses.
        pulse8 = 1'b1;
        tick(1);
        pulse8 = 1'b0;
        check_eq("t1_lock_e0", 32'(locked8), 32'd0);
        tick(1);
        check_eq("t1_lock_e1", 32'(locked8), 32'd0);
        tick(1);
        check_eq("t1_lock_e2", 32'(locked8), 32'd1);
        check_eq("t1_arm_novld", 32'(pv8), 32'd0);
        tick(2);
        for (int i = 0; i < 10; i++) begin
            push_exp(8, 1'b0, 8'd5);
            pulse_gap(8, 1, 4);
        end
        check_eq("t1_period", 32'(period8), 32'd5);
        ena8 = 1'b0;
        tick(1);
        check_eq("t1_disarm", 32'(locked8), 32'd0);

        // N=4: spacing 15 measures MAX, spacing 16 times out.
        ena4 = 1'b1;
        tick(1);
        pulse_gap(4, 1, 14);
        push_exp(4, 1'b0, 8'd15);
        pulse_gap(4, 1, 15);
        push_exp(4, 1'b1, 8'd15);
        pulse4 = 1'b1;
        tick(1);
        pulse4 = 1'b0;
        tick(1);
        check_eq("t2_unlock", 32'(locked4), 32'd0);
        check_eq("t2_hold", 32'(period4), 32'd15);
        tick(1);
        check_eq("t2_rearm", 32'(locked4), 32'd1);
        push_exp(4, 1'b0, 8'd3);
        pulse_gap(4, 1, 4);
        check_eq("t2_p3", 32'(period4), 32'd3);
        ena4 = 1'b0;
        tick(1);

        // Input high across reset release: no edge until it falls and rises again.
        reset  = 1'b1;
        pulse8 = 1'b1;
        ena8   = 1'b1;
        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_eq("t3_nolock", 32'(locked8), 32'd0);
        end
        pulse8 = 1'b0;
        tick(4);
        pulse8 = 1'b1;
        tick(3);
        check_eq("t3_arm", 32'(locked8), 32'd1);
        pulse8 = 1'b0;
        tick(3);
        ena8 = 1'b0;
        tick(1);

        // ena dropped mid-measurement of a period-7 train.
        ena8 = 1'b1;
        pulse_gap(8, 1, 6);
        push_exp(8, 1'b0, 8'd7);
        pulse_gap(8, 1, 6);
        pulse8 = 1'b1;
        ena8   = 1'b0;
        tick(1);
        pulse8 = 1'b0;
        check_eq("t4_unlock", 32'(locked8), 32'd0);
        tick(2);
        pulse8 = 1'b1;
        tick(1);
        pulse8 = 1'b0;
        tick(2);
        check_eq("t4_hold", 32'(period8), 32'd7);
        check_eq("t4_still_idle", 32'(locked8), 32'd0);
        ena8 = 1'b1;
        tick(1);
        pulse_gap(8, 1, 6);
        push_exp(8, 1'b0, 8'd7);
        pulse_gap(8, 1, 6);
        check_eq("t4_period", 32'(period8), 32'd7);
        ena8 = 1'b0;
        tick(1);

        // Reset three cycles after an arming edge.
        ena8   = 1'b1;
        pulse8 = 1'b1;
        tick(1);
        pulse8 = 1'b0;
        tick(2);
        check_eq("t5_locked", 32'(locked8), 32'd1);
        tick(3);
        reset = 1'b1;
        tick(1);
        check_eq("t5_period", 32'(period8), 32'd0);
        check_eq("t5_locked0", 32'(locked8), 32'd0);
        check_eq("t5_valid", 32'(pv8), 32'd0);
        check_eq("t5_timeout", 32'(to8), 32'd0);
        reset = 1'b0;
        tick(1);

        // Alternating input: period 2.
        pulse_gap(8, 1, 1);
        for (int i = 0; i < 6; i++) begin
            push_exp(8, 1'b0, 8'd2);
            pulse_gap(8, 1, 1);
        end
        tick(2);
        check_eq("t6_p2", 32'(period8), 32'd2);
        ena8 = 1'b0;
        tick(1);

        // High-width 3, period 9.
        ena8 = 1'b1;
        pulse_gap(8, 3, 6);
        for (int i = 0; i < 4; i++) begin
            push_exp(8, 1'b0, 8'd9);
            pulse_gap(8, 3, 6);
        end
        check_eq("t6_p9", 32'(period8), 32'd9);
        ena8 = 1'b0;
        tick(2);

        for (int i = 0; i < 20 && (q8.size() != 0 || q4.size() != 0); i++) tick(1);
        check_eq("drain8", 32'(q8.size()), 32'd0);
        check_eq("drain4", 32'(q4.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
